vga_timing_driver: RTL and testbench

- Display-side counterpart of the colour control logic. Generates 640x480@60 Hz VGA timing and issues the 19-bit pixel address ADDR to the colour logic.
- Accepts the returned 8-bit colour CIN (3-3-2 RGB), then drives HS, VS and blanked RGB to the connector.
- Compensates the colour-path latency so that sync, blank and colour stay aligned at the pins.

---
 rtl/vga_pkg.sv | 22 ++
 rtl/vga_delay_line.sv | 32 +++
 rtl/vga_timing_driver.sv | 159 +++++++++++++++
 tb/tb_vga_timing_driver.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA timing driver: 640x480@60 frame totals,
// bus widths, the last visible pixel address and the test-bar palette.
package vga_pkg;

   localparam int H_TOTAL  = 800;
   localparam int V_TOTAL  = 525;
   localparam int ADDR_W   = 19;
   localparam int COLOUR_W = 8;

   // y*640+x of the bottom-right visible pixel; ADDR parks here during vblank
   localparam int LAST_ADDR = 307199;

   // Left-to-right colours of the eight vertical test bars (3-3-2 RGB)
   localparam logic [0:7][COLOUR_W-1:0] BAR_COLOURS = {
      8'hFF, 8'hE0, 8'h1C, 8'h03, 8'hFC, 8'h1F, 8'hE3, 8'h00
   };

   function automatic int lastAddr(input int hVisible, input int vVisible);
      return hVisible * vVisible - 1;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Tick-enabled shift register that delays a WIDTH-bit word by DEPTH pixel ticks;
// reset loads every stage with RESET_VAL so blanking/inactive syncs flush out first.
module vga_delay_line #(
   parameter int                WIDTH     = 1,
   parameter int                DEPTH     = 1,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_tick,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_stage [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= RESET_VAL;
         end
      end else if (i_tick) begin
         r_stage[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_driver.sv
// 640x480@60 VGA timing generator issuing pixel addresses and re-aligning the returned colour
// with the syncs. Define VGA_TEST_PATTERN_EN to add the TEST_MODE colour-bar input.
module vga_timing_driver
   import vga_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int H_VISIBLE  = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = H_TOTAL - H_VISIBLE - H_FP - H_SYNC,
   parameter int V_VISIBLE  = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = V_TOTAL - V_VISIBLE - V_FP - V_SYNC,
   parameter int PIPE_DELAY = 1
) (
   input  logic                CLK,
   input  logic                RESET,
`ifdef VGA_TEST_PATTERN_EN
   input  logic                TEST_MODE,
`endif
   output logic [ADDR_W-1:0]   ADDR,
   input  logic [COLOUR_W-1:0] CIN,
   output logic                PIX_TICK,
   output logic                FRAME_START,
   output logic                HS,
   output logic                VS,
   output logic [COLOUR_W-1:0] RGB
);

   localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W = $clog2(CLK_DIV);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]        H_LAST    = 10'(H_TOT - 1);
   localparam logic [9:0]        V_LAST    = 10'(V_TOT - 1);
   localparam logic [9:0]        H_VIS     = 10'(H_VISIBLE);
   localparam logic [9:0]        V_VIS     = 10'(V_VISIBLE);
   localparam logic [9:0]        HS_BEGIN  = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0]        HS_END    = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0]        VS_BEGIN  = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0]        VS_END    = 10'(V_VISIBLE + V_FP + V_SYNC);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(lastAddr(H_VISIBLE, V_VISIBLE));

   logic [DIV_W-1:0]    r_div;
   logic [9:0]          r_h;
   logic [9:0]          r_v;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_hs;
   logic                r_vs;
   logic [COLOUR_W-1:0] r_rgb;

   logic                w_tick;
   logic                w_lastH;
   logic                w_lastV;
   logic                w_visible;
   logic                w_hsRaw;
   logic                w_vsRaw;
   logic [2:0]          w_rawSigs;
   logic [2:0]          w_dlySigs;
   logic                w_visD;
   logic                w_hsD;
   logic                w_vsD;
   logic [COLOUR_W-1:0] w_colour;

   assign w_tick    = (r_div == DIV_LAST);
   assign w_lastH   = (r_h == H_LAST);
   assign w_lastV   = (r_v == V_LAST);
   assign w_visible = (r_h < H_VIS) && (r_v < V_VIS);
   assign w_hsRaw   = !((r_h >= HS_BEGIN) && (r_h < HS_END));
   assign w_vsRaw   = !((r_v >= VS_BEGIN) && (r_v < VS_END));

   // ADDR advances only when leaving a visible pixel, so each line starts at y*H_VISIBLE
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_div  <= '0;
         r_h    <= '0;
         r_v    <= '0;
         r_addr <= '0;
      end else begin
         r_div <= w_tick ? '0 : r_div + 1'b1;
         if (w_tick) begin
            if (w_lastH) begin
               r_h <= '0;
               r_v <= w_lastV ? '0 : r_v + 1'b1;
            end else begin
               r_h <= r_h + 1'b1;
            end
            if (w_lastH && w_lastV) begin
               r_addr <= '0;
            end else if (w_visible && (r_addr != ADDR_LAST)) begin
               r_addr <= r_addr + 1'b1;
            end
         end
      end
   end

   assign w_rawSigs = {w_visible, w_hsRaw, w_vsRaw};

   vga_delay_line #(
      .WIDTH     (3),
      .DEPTH     (PIPE_DELAY),
      .RESET_VAL (3'b011)
   ) u_syncDelay (
      .i_clk   (CLK),
      .i_reset (RESET),
      .i_tick  (w_tick),
      .i_d     (w_rawSigs),
      .o_q     (w_dlySigs)
   );

   assign {w_visD, w_hsD, w_vsD} = w_dlySigs;

`ifdef VGA_TEST_PATTERN_EN
   localparam logic [9:0] BAR_W = 10'(H_VISIBLE / 8);

   logic [9:0] w_xD;
   logic [2:0] w_bar;

   vga_delay_line #(
      .WIDTH     (10),
      .DEPTH     (PIPE_DELAY),
      .RESET_VAL (10'd0)
   ) u_xDelay (
      .i_clk   (CLK),
      .i_reset (RESET),
      .i_tick  (w_tick),
      .i_d     (r_h),
      .o_q     (w_xD)
   );

   assign w_bar    = 3'(w_xD / BAR_W);
   assign w_colour = TEST_MODE ? BAR_COLOURS[w_bar] : CIN;
`else
   assign w_colour = CIN;
`endif

   // Blank gating happens before the pin register, so an undefined CIN in blanking never reaches RGB
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_hs  <= 1'b1;
         r_vs  <= 1'b1;
         r_rgb <= '0;
      end else if (w_tick) begin
         r_hs  <= w_hsD;
         r_vs  <= w_vsD;
         r_rgb <= w_visD ? w_colour : '0;
      end
   end

   assign ADDR        = r_addr;
   assign PIX_TICK    = w_tick;
   assign FRAME_START = w_tick && (r_h == '0) && (r_v == '0);
   assign HS          = r_hs;
   assign VS          = r_vs;
   assign RGB         = r_rgb;

endmodule

// File: tb/tb_vga_timing_driver.sv
// Self-checking bench for vga_timing_driver on a shrunken raster, with random colours
// and random mid-frame resets checked against a tick-indexed arithmetic model.
module tb_vga_timing_driver;

   localparam int CD  = 3;
   localparam int HV  = 16;
   localparam int HF  = 3;
   localparam int HSY = 5;
   localparam int HB  = 4;
   localparam int VV  = 6;
   localparam int VF  = 2;
   localparam int VSY = 2;
   localparam int VB  = 3;
   localparam int PD  = 2;

   localparam int HT   = HV + HF + HSY + HB;
   localparam int VT   = VV + VF + VSY + VB;
   localparam int FT   = HT * VT;
   localparam int LAST = HV * VV - 1;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [7:0]  CIN = 8'h00;
   logic [18:0] ADDR;
   logic        PIX_TICK;
   logic        FRAME_START;
   logic        HS;
   logic        VS;
   logic [7:0]  RGB;
`ifdef VGA_TEST_PATTERN_EN
   logic        TEST_MODE = 1'b0;
`endif

   int   checks = 0;
   int   fails = 0;
   int   n = 0;
   bit   firstGap = 1'b0;
   bit   tm = 1'b0;
   logic [7:0] colourMem [HV*VV];
   logic [7:0] barColours [8] = '{8'hFF, 8'hE0, 8'h1C, 8'h03, 8'hFC, 8'h1F, 8'hE3, 8'h00};

   vga_timing_driver #(
      .CLK_DIV    (CD),
      .H_VISIBLE  (HV),
      .H_FP       (HF),
      .H_SYNC     (HSY),
      .H_BP       (HB),
      .V_VISIBLE  (VV),
      .V_FP       (VF),
      .V_SYNC     (VSY),
      .V_BP       (VB),
      .PIPE_DELAY (PD)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
`ifdef VGA_TEST_PATTERN_EN
      .TEST_MODE   (TEST_MODE),
`endif
      .ADDR        (ADDR),
      .CIN         (CIN),
      .PIX_TICK    (PIX_TICK),
      .FRAME_START (FRAME_START),
      .HS          (HS),
      .VS          (VS),
      .RGB         (RGB)
   );

   always #5 CLK = ~CLK;

   // Address the colour logic should see for raster position p of a frame
   function automatic int modelAddr(input int p);
      int h;
      int v;
      h = p % HT;
      v = p / HT;
      if (v >= VV) return LAST;
      if (h < HV) return v * HV + h;
      return ((v + 1) * HV > LAST) ? LAST : (v + 1) * HV;
   endfunction

   function automatic bit modelVisible(input int p);
      return ((p % HT) < HV) && ((p / HT) < VV);
   endfunction

   function automatic logic modelHs(input int q);
      int h;
      if (q < 0) return 1'b1;
      h = (q % FT) % HT;
      return !((h >= HV + HF) && (h < HV + HF + HSY));
   endfunction

   function automatic logic modelVs(input int q);
      int v;
      if (q < 0) return 1'b1;
      v = (q % FT) / HT;
      return !((v >= VV + VF) && (v < VV + VF + VSY));
   endfunction

   function automatic logic [7:0] modelRgb(input int q);
      int p;
      if (q < 0) return 8'h00;
      p = q % FT;
      if (!modelVisible(p)) return 8'h00;
      if (tm) return barColours[(p % HT) / (HV / 8)];
      return colourMem[modelAddr(p)];
   endfunction

   // Colour logic stand-in: colour for the address issued PD ticks ago, X while blanked
   function automatic logic [7:0] cinFor(input int t);
      int q;
      int p;
      q = t - PD;
      if (q < 0) return 8'bx;
      p = q % FT;
      if (!modelVisible(p)) return 8'bx;
      return colourMem[modelAddr(p)];
   endfunction

   // Advance to the next PIX_TICK cycle (bounded) and present CIN for that tick edge
   task automatic applyStimulus(output bit ok, output int gap);
      ok = 1'b0;
      gap = 0;
      for (int c = 0; c < CD + 2 && !ok; c++) begin
         @(negedge CLK);
         gap++;
         if (PIX_TICK === 1'b1) ok = 1'b1;
      end
      if (ok) CIN = cinFor(n);
   endtask

   task automatic test_reset;
      RESET = 1'b1;
      repeat (3) @(negedge CLK);
      checks++;
      if (ADDR !== 19'd0) begin
         fails++; $display("[TB] FAIL reset_addr got=%0d exp=0", ADDR);
      end
      checks++;
      if (HS !== 1'b1 || VS !== 1'b1) begin
         fails++; $display("[TB] FAIL reset_sync got HS=%b VS=%b exp HS=1 VS=1", HS, VS);
      end
      checks++;
      if (RGB !== 8'h00) begin
         fails++; $display("[TB] FAIL reset_rgb got=%h exp=00", RGB);
      end
      checks++;
      if (PIX_TICK !== 1'b0 || FRAME_START !== 1'b0) begin
         fails++; $display("[TB] FAIL reset_pulses got PIX_TICK=%b FRAME_START=%b exp 0 0", PIX_TICK, FRAME_START);
      end
      RESET = 1'b0;
      n = 0;
      firstGap = 1'b1;
   endtask

   task automatic test_frame(input int ticks);
      bit ok;
      int gap;
      int expGap;
      int p;
      int q;
      for (int i = 0; i < ticks; i++) begin
         applyStimulus(ok, gap);
         checks++;
         if (!ok) begin
            fails++; $display("[TB] FAIL pix_tick_timeout n=%0d got no tick within %0d cycles", n, CD + 2);
            return;
         end
         expGap = firstGap ? CD - 1 : CD;
         firstGap = 1'b0;
         p = n % FT;
         q = n - 1 - PD;
         checks++;
         if (gap !== expGap) begin
            fails++; $display("[TB] FAIL tick_period n=%0d got=%0d exp=%0d", n, gap, expGap);
         end
         checks++;
         if (ADDR !== 19'(modelAddr(p))) begin
            fails++; $display("[TB] FAIL addr n=%0d h=%0d v=%0d got=%0d exp=%0d", n, p % HT, p / HT, ADDR, modelAddr(p));
         end
         checks++;
         if (FRAME_START !== 1'(p == 0)) begin
            fails++; $display("[TB] FAIL frame_start n=%0d got=%b exp=%b", n, FRAME_START, p == 0);
         end
         checks++;
         if (HS !== modelHs(q)) begin
            fails++; $display("[TB] FAIL hs n=%0d got=%b exp=%b", n, HS, modelHs(q));
         end
         checks++;
         if (VS !== modelVs(q)) begin
            fails++; $display("[TB] FAIL vs n=%0d got=%b exp=%b", n, VS, modelVs(q));
         end
         checks++;
         if (RGB !== modelRgb(q)) begin
            fails++; $display("[TB] FAIL rgb n=%0d got=%h exp=%h", n, RGB, modelRgb(q));
         end
         n++;
      end
   endtask

   task automatic test_midframe_reset(input int iterations);
      int runTicks;
      int skew;
      for (int it = 0; it < iterations; it++) begin
         runTicks = int'($urandom_range(FT + 40, 20));
         test_frame(runTicks);
         skew = int'($urandom_range(CD - 2, 0));
         repeat (skew) @(negedge CLK);
         RESET = 1'b1;
         @(negedge CLK);
         checks++;
         if (HS !== 1'b1 || VS !== 1'b1 || RGB !== 8'h00) begin
            fails++; $display("[TB] FAIL midreset_pins got HS=%b VS=%b RGB=%h exp 1 1 00", HS, VS, RGB);
         end
         checks++;
         if (ADDR !== 19'd0 || PIX_TICK !== 1'b0) begin
            fails++; $display("[TB] FAIL midreset_state got ADDR=%0d PIX_TICK=%b exp 0 0", ADDR, PIX_TICK);
         end
         RESET = 1'b0;
         n = 0;
         firstGap = 1'b1;
         test_frame(FT + PD + 3);
      end
   endtask

`ifdef VGA_TEST_PATTERN_EN
   task automatic test_pattern;
      tm = 1'b1;
      TEST_MODE = 1'b1;
      test_frame(FT + PD + 3);
      tm = 1'b0;
      TEST_MODE = 1'b0;
      test_frame(PD + 2 + HT);
   endtask
`endif

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < HV * VV; i++) colourMem[i] = 8'($urandom);
      test_reset();
      test_frame(2 * FT + 7);
      test_midframe_reset(3);
`ifdef VGA_TEST_PATTERN_EN
      test_pattern();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
